serial_subtractor_16bits: RTL
=============================

// Module: serial_subtractor_16bits
// PURPOSE
//  Multi-cycle subtractor D = A - B. It complements the ripple-carry adder family.
//  - Processes DIGIT_W bits per cycle, LSB-first, through one DIGIT_W-bit adder slice
//    that computes A + ~B + 1.
//  - Used where area matters more than latency; results are registered and flagged.
//  - Sits beside the combinational adders under somadores; start/done handshake.
// PARAMETERS
//  WIDTH    16  operand/result width in bits
//  DIGIT_W  1   bits processed per cycle; must divide WIDTH (1,2,4,8,16 legal)
// PORTS
//  clk    input   1      clock, rising edge
//  rst    input   1      synchronous, active-high reset
//  start  input   1      request: sample A, B on this edge if busy=0
//  A      input   WIDTH  minuend (unsigned or two's complement)
//  B      input   WIDTH  subtrahend
//  busy   output  1      1 while an operation is in progress (state RUN)
//  done   output  1      one-cycle pulse: D/Bout/V/Z valid from this cycle
//  D      output  WIDTH  difference A - B, mod 2^WIDTH
//  Bout   output  1      borrow out: 1 iff A < B as unsigned (= ~final carry)
//  V      output  1      signed overflow: A[msb]!=B[msb] && D[msb]!=A[msb]
//  Z      output  1      1 iff D == 0
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, D, Bout, V, Z all 0; internal regs cleared.
//    rst has priority and aborts any operation; no done pulse follows.
//  - N = WIDTH/DIGIT_W slices. FSM states are IDLE, RUN, DONE.
//  - IDLE/DONE, start=1: latch a_sh=A, b_sh=~B, carry=1, cnt=0, save A[msb]/B[msb];
//    goto RUN. start=0: IDLE -> stay; DONE -> IDLE.
//  - RUN, each cycle:
//    - Compute {c, s} = a_sh[DIGIT_W-1:0] + b_sh[DIGIT_W-1:0] + carry.
//    - Load s into the top of the result shift register, which shifts right by DIGIT_W.
//    - Shift a_sh/b_sh right by DIGIT_W; carry=c; cnt++.
//    - When cnt==N-1: goto DONE, and write D, Bout=~c, V, Z from the final values on that edge.
//  - busy=1 exactly in RUN. done=1 exactly in DONE (single cycle).
//  - Latency: start sampled at edge k -> done high in the cycle after edge k+N.
//    DIGIT_W=1: done is seen N=16 cycles after the start edge.
//  - Back-to-back: start=1 while done=1 is accepted. RUN follows directly, and
//    D/flags keep the old result until the new done.
//  - start=1 while busy=1 is ignored; A/B changes during RUN have no effect.
//  - D, Bout, V, Z hold their last value until the next completion or reset.
//  - No combinational path from inputs to outputs.
//  - Arithmetic: the carry chain is exactly one DIGIT_W-bit slice wide.
//    Carry-in of the first slice is 1 (two's complement of B).
// TESTING (WIDTH=16, DIGIT_W=1 unless noted)
//  1. A=0x1234, B=0x0034, start 1 cycle -> after 16 cycles done=1; D=0x1200, Bout=0, V=0, Z=0
//  2. A=0x0000, B=0x0001 -> D=0xFFFF, Bout=1, V=0, Z=0; A=0x8000, B=0x0001 -> D=0x7FFF, Bout=0, V=1
//  3. A=B=0xBEEF -> D=0x0000, Z=1, Bout=0, V=0; start held high during RUN -> one op only, busy 16 cycles
//  4. rst asserted at cycle 7 of RUN -> next cycle busy=0, done=0, D=0, flags 0; no done pulse afterwards
//  5. Back-to-back: start held during the done cycle with A=0x0005, B=0x0007 -> second done 16 cycles later
//     with D=0xFFFE, Bout=1
//  6. DIGIT_W=4 and DIGIT_W=16: repeat 1-2 -> done after 4 and 1 cycles; 10k random vectors match A-B

Source files
------------

// File: rtl/serial_subtractor_16bits.sv
// Digit-serial subtractor D = A - B: one DIGIT_W-bit slice of A + ~B + 1 per cycle, LSB first.
// Start is sampled in IDLE/DONE, done pulses N=WIDTH/DIGIT_W cycles later, and results hold until the next completion.
module serial_subtractor_16bits #(
  parameter int WIDTH   = 16,
  parameter int DIGIT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             Z
);

  localparam int N     = WIDTH / DIGIT_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               bout_q, bout_d;
  logic               v_q, v_d;
  logic               z_q, z_d;

  logic [DIGIT_W:0]   sum;
  logic [WIDTH-1:0]   res_shift;
  logic               last;

  // The only carry chain in the design: a single DIGIT_W-bit slice.
  assign sum       = {1'b0, a_sh_q[DIGIT_W-1:0]} + {1'b0, b_sh_q[DIGIT_W-1:0]}
                   + {{DIGIT_W{1'b0}}, carry_q};
  assign res_shift = WIDTH'({sum[DIGIT_W-1:0], res_q} >> DIGIT_W);
  assign last      = (cnt_q == CNT_W'(N - 1));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    d_d     = d_q;
    bout_d  = bout_q;
    v_d     = v_q;
    z_d     = z_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = A;
          b_sh_d  = ~B;
          carry_d = 1'b1;
          cnt_d   = '0;
          a_msb_d = A[WIDTH-1];
          b_msb_d = B[WIDTH-1];
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_d   = res_shift;
        a_sh_d  = a_sh_q >> DIGIT_W;
        b_sh_d  = b_sh_q >> DIGIT_W;
        carry_d = sum[DIGIT_W];
        cnt_d   = cnt_q + CNT_W'(1);
        if (last) begin
          // Flags come from the final slice so they land on the same edge as D.
          state_d = DONE;
          d_d     = res_shift;
          bout_d  = ~sum[DIGIT_W];
          v_d     = (a_msb_q ^ b_msb_q) & (res_shift[WIDTH-1] ^ a_msb_q);
          z_d     = (res_shift == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign D    = d_q;
  assign Bout = bout_q;
  assign V    = v_q;
  assign Z    = z_q;

endmodule
